regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file. Next generation of the 8x16 three-read / one-write register file.
- Adds a second write port, optional write-to-read bypass, an optional hardwired zero register, a per-register pending scoreboard and a sequential soft-clear engine.
- Sits between decode (read addresses, scoreboard) and writeback (two result buses) of the datapath.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers (derived, not overridable).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored contents only.
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, and never goes pending.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nRESET  in  1  asynchronous active-low reset.
- we_a  in  1  write enable, port A.
- waddr_a  in  ADDR_W  write address, port A.
- wdata_a  in  DATA_W  write data, port A.
- we_b  in  1  write enable, port B.
- waddr_b  in  ADDR_W  write address, port B.
- wdata_b  in  DATA_W  write data, port B.
- raddr_0, raddr_1, raddr_2  in  ADDR_W each  read addresses.
- rdata_0, rdata_1, rdata_2  out  DATA_W each  combinational read data.
- pend_0, pend_1, pend_2  out  1 each  pending bit of the register at raddr_n (combinational).
- set_pend  in  1  mark register set_pend_addr pending.
- set_pend_addr  in  ADDR_W  register to mark pending.
- clear_req  in  1  start a soft clear of all registers.
- busy  out  1  high while the soft clear runs.

Behaviour:
- Reset (nRESET low, asynchronous): all registers 0, all pending bits 0, FSM in IDLE, clear pointer 0, busy 0. Outputs then follow the combinational read rules, so rdata = 0 and pend = 0.
- Write: on the clock edge, reg[waddr_a] <= wdata_a when we_a, and reg[waddr_b] <= wdata_b when we_b.
- Write collision: if both ports write the same address in one cycle, port B wins.
- Pending clear on write: a write from either port clears pend[waddr].
- Pending set: set_pend sets pend[set_pend_addr] at the clock edge. If set_pend and a write hit the same address in one cycle, the set wins and the bit ends at 1; the data write still happens.
- Read: rdata_n = reg[raddr_n], zero latency. Any number of ports may read the same address.
- Bypass (BYPASS=1, FSM in IDLE):
  - if we_b and waddr_b == raddr_n, then rdata_n = wdata_b;
  - else if we_a and waddr_a == raddr_n, then rdata_n = wdata_a;
  - else stored value.
  - pend_n is never bypassed; it shows the registered bit.
- No bypass (BYPASS=0): a written value is visible from the cycle after the write.
- ZERO_REG=1: writes to address 0 are dropped, set_pend to address 0 is dropped, a read of address 0 returns 0 with pend 0, and bypass never applies to address 0.
- Soft-clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_req=1; ptr <= 0.
  - In CLEAR, each cycle: reg[ptr] <= 0, pend[ptr] <= 0, ptr <= ptr+1.
  - CLEAR -> IDLE on the edge that clears ptr = DEPTH-1.
  - busy = 1 exactly while the state is CLEAR, i.e. DEPTH cycles starting the cycle after clear_req is sampled.
- During CLEAR:
  - we_a, we_b and set_pend are ignored (dropped, not queued); clear_req is ignored.
  - Reads return current contents, so already-cleared registers read 0.
  - Bypass is disabled.
- clear_req in the same cycle as a write (IDLE): that write is performed, and the clear then starts next cycle and overwrites it.
- Reset during CLEAR: immediate return to IDLE, all state zeroed.
- Pointer width: ptr is ADDR_W bits; the wrap from DEPTH-1 to 0 coincides with the exit to IDLE.

Test Plan:
- Reset, then write A addr3=0x1234 and B addr5=0xBEEF in the same cycle; next cycle read 3/5/0 -> 0x1234, 0xBEEF, 0x0000.
- Collision: A and B both write addr2 (A=0x1111, B=0x2222), with raddr_0=2 in the same cycle. BYPASS=1 -> rdata_0=0x2222 in that cycle and stored 0x2222 after. BYPASS=0 -> rdata_0=0 in that cycle, 0x2222 next cycle.
- Scoreboard:
  - set_pend addr4 -> pend_x=1 for raddr=4 next cycle;
  - write A addr4 -> pend 0 next cycle;
  - set_pend and write B to addr4 in the same cycle -> pend stays 1, data updated.
- ZERO_REG=1: write 0xFFFF to addr0 and set_pend addr0 -> rdata=0, pend=0. The same stimulus with ZERO_REG=0 -> rdata=0xFFFF, pend=1.
- Soft clear, DEPTH=8:
  - fill all registers with 0xA5A5, then pulse clear_req;
  - busy is high exactly 8 cycles, and reg k reads 0 from cycle k+1 onward;
  - a write to addr7 at cycle 3 of the clear is dropped;
  - all pending bits are 0 at the end.
- Reset mid-clear: assert nRESET low at clear cycle 4 -> busy=0 immediately; after release all registers read 0 and a write to addr1 is accepted on the next edge.

Source files
------------

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Purpose  : Write, read, scoreboard and clear-control bundle for regfile_mp
// Revision : 1.0
// ============================================================================
interface regfile_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              we_a;
    logic [ADDR_W-1:0] waddr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              we_b;
    logic [ADDR_W-1:0] waddr_b;
    logic [DATA_W-1:0] wdata_b;
    logic [ADDR_W-1:0] raddr_0;
    logic [ADDR_W-1:0] raddr_1;
    logic [ADDR_W-1:0] raddr_2;
    logic [DATA_W-1:0] rdata_0;
    logic [DATA_W-1:0] rdata_1;
    logic [DATA_W-1:0] rdata_2;
    logic              pend_0;
    logic              pend_1;
    logic              pend_2;
    logic              set_pend;
    logic [ADDR_W-1:0] set_pend_addr;
    logic              clear_req;
    logic              busy;

    modport master (
        output we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b,
        output raddr_0, raddr_1, raddr_2, set_pend, set_pend_addr, clear_req,
        input  rdata_0, rdata_1, rdata_2, pend_0, pend_1, pend_2, busy
    );

    modport slave (
        input  we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b,
        input  raddr_0, raddr_1, raddr_2, set_pend, set_pend_addr, clear_req,
        output rdata_0, rdata_1, rdata_2, pend_0, pend_1, pend_2, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : 3-read / 2-write register file with bypass, pending scoreboard
//            and a sequential soft-clear engine
// Revision : 1.0
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  wire logic   clk,
    input  wire logic   nRESET,
    regfile_mp_if.slave bus
);
    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_NRD   = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             r_state_q;
    state_t             w_state_d;
    logic [ADDR_W-1:0]  r_ptr_q;
    logic [ADDR_W-1:0]  w_ptr_d;
    logic [DATA_W-1:0]  r_mem_q [c_DEPTH];
    logic [DATA_W-1:0]  w_mem_d [c_DEPTH];
    logic [c_DEPTH-1:0] r_pend_q;
    logic [c_DEPTH-1:0] w_pend_d;

    logic               w_wr_a;
    logic               w_wr_b;
    logic               w_set;
    logic               w_byp_en;
    logic [ADDR_W-1:0]  w_raddr   [c_NRD];
    logic [DATA_W-1:0]  w_rdata   [c_NRD];
    logic [c_NRD-1:0]   w_pend_rd;

    // With ZERO_REG, address 0 never accepts data or a pending mark.
    assign w_wr_a   = bus.we_a && !(ZERO_REG != 0 && bus.waddr_a == '0);
    assign w_wr_b   = bus.we_b && !(ZERO_REG != 0 && bus.waddr_b == '0);
    assign w_set    = bus.set_pend && !(ZERO_REG != 0 && bus.set_pend_addr == '0);
    assign w_byp_en = (BYPASS != 0) && (r_state_q == ST_IDLE);

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_mem_d   = r_mem_q;
        w_pend_d  = r_pend_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_wr_a) begin
                    w_mem_d[bus.waddr_a]  = bus.wdata_a;
                    w_pend_d[bus.waddr_a] = 1'b0;
                end
                // Port B after port A so B wins an address collision.
                if (w_wr_b) begin
                    w_mem_d[bus.waddr_b]  = bus.wdata_b;
                    w_pend_d[bus.waddr_b] = 1'b0;
                end
                if (w_set) begin
                    w_pend_d[bus.set_pend_addr] = 1'b1;
                end
                if (bus.clear_req) begin
                    w_state_d = ST_CLEAR;
                    w_ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                w_mem_d[r_ptr_q]  = '0;
                w_pend_d[r_ptr_q] = 1'b0;
                w_ptr_d           = r_ptr_q + 1'b1;
                if (r_ptr_q == ADDR_W'(c_DEPTH - 1)) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state_q <= ST_IDLE;
            r_ptr_q   <= '0;
            r_pend_q  <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_pend_q  <= w_pend_d;
            r_mem_q   <= w_mem_d;
        end
    end

    assign w_raddr[0] = bus.raddr_0;
    assign w_raddr[1] = bus.raddr_1;
    assign w_raddr[2] = bus.raddr_2;

    // Pending bits are never forwarded; only data takes the bypass path.
    always_comb begin
        for (int n = 0; n < c_NRD; n++) begin
            w_rdata[n]   = r_mem_q[w_raddr[n]];
            w_pend_rd[n] = r_pend_q[w_raddr[n]];
            if (ZERO_REG != 0 && w_raddr[n] == '0) begin
                w_rdata[n]   = '0;
                w_pend_rd[n] = 1'b0;
            end else if (w_byp_en && bus.we_b && bus.waddr_b == w_raddr[n]) begin
                w_rdata[n] = bus.wdata_b;
            end else if (w_byp_en && bus.we_a && bus.waddr_a == w_raddr[n]) begin
                w_rdata[n] = bus.wdata_a;
            end
        end
    end

    assign bus.rdata_0 = w_rdata[0];
    assign bus.rdata_1 = w_rdata[1];
    assign bus.rdata_2 = w_rdata[2];
    assign bus.pend_0  = w_pend_rd[0];
    assign bus.pend_1  = w_pend_rd[1];
    assign bus.pend_2  = w_pend_rd[2];
    assign bus.busy    = (r_state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench; dut0 = BYPASS 1 / ZERO_REG 0,
//            dut1 = BYPASS 0 / ZERO_REG 1, both driven with identical stimulus
// Revision : 1.0
// ============================================================================
module tb_regfile_mp;
    logic clk;
    logic nRESET;
    int   n_checks;
    int   n_fail;

    regfile_mp_if #(.DATA_W(16), .ADDR_W(3)) if0 ();
    regfile_mp_if #(.DATA_W(16), .ADDR_W(3)) if1 ();

    assign if1.we_a          = if0.we_a;
    assign if1.waddr_a       = if0.waddr_a;
    assign if1.wdata_a       = if0.wdata_a;
    assign if1.we_b          = if0.we_b;
    assign if1.waddr_b       = if0.waddr_b;
    assign if1.wdata_b       = if0.wdata_b;
    assign if1.raddr_0       = if0.raddr_0;
    assign if1.raddr_1       = if0.raddr_1;
    assign if1.raddr_2       = if0.raddr_2;
    assign if1.set_pend      = if0.set_pend;
    assign if1.set_pend_addr = if0.set_pend_addr;
    assign if1.clear_req     = if0.clear_req;

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut0 (
        .clk(clk), .nRESET(nRESET), .bus(if0));
    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(0), .ZERO_REG(1)) dut1 (
        .clk(clk), .nRESET(nRESET), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays plus a count of clear cycles still to run.
    logic [15:0] m_mem  [2][8];
    logic        m_pend [2][8];
    int          m_clr  [2];
    int          m_idx  [2];

    function automatic bit bp(int d); return d == 0; endfunction
    function automatic bit zr(int d); return d == 1; endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_clr[d] = 0;
            m_idx[d] = 0;
            for (int k = 0; k < 8; k++) begin
                m_mem[d][k]  = 16'h0000;
                m_pend[d][k] = 1'b0;
            end
        end
    endfunction

    function automatic void model_update();
        if (!nRESET) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            if (m_clr[d] > 0) begin
                m_mem[d][m_idx[d]]  = 16'h0000;
                m_pend[d][m_idx[d]] = 1'b0;
                m_idx[d]++;
                m_clr[d]--;
            end else begin
                if (if0.we_a && !(zr(d) && if0.waddr_a == 3'd0)) begin
                    m_mem[d][if0.waddr_a]  = if0.wdata_a;
                    m_pend[d][if0.waddr_a] = 1'b0;
                end
                if (if0.we_b && !(zr(d) && if0.waddr_b == 3'd0)) begin
                    m_mem[d][if0.waddr_b]  = if0.wdata_b;
                    m_pend[d][if0.waddr_b] = 1'b0;
                end
                if (if0.set_pend && !(zr(d) && if0.set_pend_addr == 3'd0))
                    m_pend[d][if0.set_pend_addr] = 1'b1;
                if (if0.clear_req) begin
                    m_clr[d] = 8;
                    m_idx[d] = 0;
                end
            end
        end
    endfunction

    function automatic logic [2:0] ra(int n);
        return (n == 0) ? if0.raddr_0 : (n == 1) ? if0.raddr_1 : if0.raddr_2;
    endfunction

    function automatic logic [15:0] exp_rd(int d, int n);
        logic [2:0] a;
        a = ra(n);
        if (zr(d) && a == 3'd0) return 16'h0000;
        if (bp(d) && m_clr[d] == 0) begin
            if (if0.we_b && if0.waddr_b == a) return if0.wdata_b;
            if (if0.we_a && if0.waddr_a == a) return if0.wdata_a;
        end
        return m_mem[d][a];
    endfunction

    function automatic logic exp_pd(int d, int n);
        logic [2:0] a;
        a = ra(n);
        if (zr(d) && a == 3'd0) return 1'b0;
        return m_pend[d][a];
    endfunction

    function automatic logic exp_busy(int d);
        return m_clr[d] > 0;
    endfunction

    function automatic logic [15:0] obs_rd(int d, int n);
        if (d == 0) return (n == 0) ? if0.rdata_0 : (n == 1) ? if0.rdata_1 : if0.rdata_2;
        return (n == 0) ? if1.rdata_0 : (n == 1) ? if1.rdata_1 : if1.rdata_2;
    endfunction

    function automatic logic obs_pd(int d, int n);
        if (d == 0) return (n == 0) ? if0.pend_0 : (n == 1) ? if0.pend_1 : if0.pend_2;
        return (n == 0) ? if1.pend_0 : (n == 1) ? if1.pend_1 : if1.pend_2;
    endfunction

    function automatic logic obs_busy(int d);
        return (d == 0) ? if0.busy : if1.busy;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if0.we_a = 1'b0; if0.waddr_a = 3'd0; if0.wdata_a = 16'h0000;
        if0.we_b = 1'b0; if0.waddr_b = 3'd0; if0.wdata_b = 16'h0000;
        if0.set_pend = 1'b0; if0.set_pend_addr = 3'd0; if0.clear_req = 1'b0;
    endtask

    task automatic set_reads(logic [2:0] a0, logic [2:0] a1, logic [2:0] a2);
        if0.raddr_0 = a0; if0.raddr_1 = a1; if0.raddr_2 = a2;
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        idle_inputs();
        set_reads(3'd1, 3'd4, 3'd7);
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_busy(d) !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy dut%0d: got %0b expected 0", d, obs_busy(d));
            end
            for (int n = 0; n < 3; n++) begin
                n_checks += 2;
                if (obs_rd(d, n) !== 16'h0000) begin
                    n_fail++; $display("FAIL reset_rdata%0d dut%0d: got %h expected 0000", n, d, obs_rd(d, n));
                end
                if (obs_pd(d, n) !== 1'b0) begin
                    n_fail++; $display("FAIL reset_pend%0d dut%0d: got %0b expected 0", n, d, obs_pd(d, n));
                end
            end
        end
        tick();
        nRESET = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        logic [15:0] want [3];
        want[0] = 16'h1234; want[1] = 16'hBEEF; want[2] = 16'h0000;
        if0.we_a = 1'b1; if0.waddr_a = 3'd3; if0.wdata_a = 16'h1234;
        if0.we_b = 1'b1; if0.waddr_b = 3'd5; if0.wdata_b = 16'hBEEF;
        tick();
        idle_inputs();
        set_reads(3'd3, 3'd5, 3'd0);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 3; n++) begin
                n_checks++;
                if (obs_rd(d, n) !== want[n] || obs_rd(d, n) !== exp_rd(d, n)) begin
                    n_fail++; $display("FAIL write_read rdata%0d dut%0d: got %h expected %h", n, d, obs_rd(d, n), want[n]);
                end
            end
        end
    endtask

    task automatic test_collision();
        set_reads(3'd2, 3'd3, 3'd5);
        if0.we_a = 1'b1; if0.waddr_a = 3'd2; if0.wdata_a = 16'h1111;
        if0.we_b = 1'b1; if0.waddr_b = 3'd2; if0.wdata_b = 16'h2222;
        #1;
        n_checks += 2;
        if (obs_rd(0, 0) !== 16'h2222) begin
            n_fail++; $display("FAIL collision_bypass dut0: got %h expected 2222", obs_rd(0, 0));
        end
        if (obs_rd(1, 0) !== 16'h0000) begin
            n_fail++; $display("FAIL collision_nobypass dut1: got %h expected 0000", obs_rd(1, 0));
        end
        tick();
        idle_inputs();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_rd(d, 0) !== 16'h2222) begin
                n_fail++; $display("FAIL collision_stored dut%0d: got %h expected 2222", d, obs_rd(d, 0));
            end
        end
    endtask

    task automatic test_scoreboard();
        set_reads(3'd4, 3'd4, 3'd4);
        if0.set_pend = 1'b1; if0.set_pend_addr = 3'd4;
        tick();
        idle_inputs();
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 3; n++) begin
                n_checks++;
                if (obs_pd(d, n) !== 1'b1) begin
                    n_fail++; $display("FAIL pend_set%0d dut%0d: got %0b expected 1", n, d, obs_pd(d, n));
                end
            end
        end
        if0.we_a = 1'b1; if0.waddr_a = 3'd4; if0.wdata_a = 16'h0404;
        tick();
        idle_inputs();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_pd(d, 1) !== 1'b0) begin
                n_fail++; $display("FAIL pend_clear dut%0d: got %0b expected 0", d, obs_pd(d, 1));
            end
        end
        if0.set_pend = 1'b1; if0.set_pend_addr = 3'd4;
        if0.we_b = 1'b1; if0.waddr_b = 3'd4; if0.wdata_b = 16'h4444;
        tick();
        idle_inputs();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks += 2;
            if (obs_pd(d, 2) !== 1'b1) begin
                n_fail++; $display("FAIL pend_set_wins dut%0d: got %0b expected 1", d, obs_pd(d, 2));
            end
            if (obs_rd(d, 2) !== 16'h4444) begin
                n_fail++; $display("FAIL pend_set_data dut%0d: got %h expected 4444", d, obs_rd(d, 2));
            end
        end
    endtask

    task automatic test_zero_reg();
        set_reads(3'd0, 3'd0, 3'd0);
        if0.we_a = 1'b1; if0.waddr_a = 3'd0; if0.wdata_a = 16'hFFFF;
        if0.set_pend = 1'b1; if0.set_pend_addr = 3'd0;
        #1;
        n_checks += 2;
        if (obs_rd(0, 0) !== 16'hFFFF) begin
            n_fail++; $display("FAIL zero_bypass dut0: got %h expected ffff", obs_rd(0, 0));
        end
        if (obs_rd(1, 0) !== 16'h0000) begin
            n_fail++; $display("FAIL zero_bypass dut1: got %h expected 0000", obs_rd(1, 0));
        end
        tick();
        idle_inputs();
        #1;
        n_checks += 4;
        if (obs_rd(0, 1) !== 16'hFFFF) begin
            n_fail++; $display("FAIL zero_reg_data dut0: got %h expected ffff", obs_rd(0, 1));
        end
        if (obs_pd(0, 1) !== 1'b1) begin
            n_fail++; $display("FAIL zero_reg_pend dut0: got %0b expected 1", obs_pd(0, 1));
        end
        if (obs_rd(1, 1) !== 16'h0000) begin
            n_fail++; $display("FAIL zero_reg_data dut1: got %h expected 0000", obs_rd(1, 1));
        end
        if (obs_pd(1, 1) !== 1'b0) begin
            n_fail++; $display("FAIL zero_reg_pend dut1: got %0b expected 0", obs_pd(1, 1));
        end
    endtask

    task automatic fill_all();
        for (int k = 0; k < 8; k++) begin
            if0.we_a = 1'b1; if0.waddr_a = 3'(k); if0.wdata_a = 16'hA5A5;
            if0.set_pend = 1'b1; if0.set_pend_addr = 3'((k + 3) % 8);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_soft_clear();
        int busy_cycles;
        fill_all();
        if0.clear_req = 1'b1;
        if0.we_b = 1'b1; if0.waddr_b = 3'd6; if0.wdata_b = 16'h6666;
        #1;
        n_checks++;
        if (obs_busy(0) !== 1'b0) begin
            n_fail++; $display("FAIL clear_req_cycle_busy dut0: got %0b expected 0", obs_busy(0));
        end
        tick();
        idle_inputs();
        busy_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            set_reads(3'(c), 3'((c + 7) % 8), 3'd7);
            if (c == 3) begin
                if0.we_a = 1'b1; if0.waddr_a = 3'd7; if0.wdata_a = 16'h7777;
            end
            #1;
            if (obs_busy(0) === 1'b1) busy_cycles++;
            n_checks += 2;
            if (obs_rd(0, 2) !== 16'hA5A5) begin
                n_fail++; $display("FAIL clear_reg7 cycle%0d: got %h expected a5a5", c, obs_rd(0, 2));
            end
            if (obs_rd(0, 0) !== ((c == 6) ? 16'h6666 : 16'hA5A5)) begin
                n_fail++; $display("FAIL clear_not_yet cycle%0d: got %h", c, obs_rd(0, 0));
            end
            if (c > 0) begin
                n_checks++;
                if (obs_rd(0, 1) !== 16'h0000) begin
                    n_fail++; $display("FAIL clear_done cycle%0d: got %h expected 0000", c, obs_rd(0, 1));
                end
            end
            for (int d = 0; d < 2; d++) begin
                for (int n = 0; n < 3; n++) begin
                    n_checks++;
                    if (obs_rd(d, n) !== exp_rd(d, n)) begin
                        n_fail++; $display("FAIL clear_model rdata%0d dut%0d cycle%0d: got %h expected %h", n, d, c, obs_rd(d, n), exp_rd(d, n));
                    end
                end
            end
            tick();
            idle_inputs();
        end
        n_checks += 2;
        if (busy_cycles != 8) begin
            n_fail++; $display("FAIL clear_busy_len: got %0d expected 8", busy_cycles);
        end
        if (obs_busy(0) !== 1'b0 || obs_busy(1) !== 1'b0) begin
            n_fail++; $display("FAIL clear_busy_end: got %0b%0b expected 00", obs_busy(0), obs_busy(1));
        end
        for (int k = 0; k < 8; k++) begin
            set_reads(3'(k), 3'(k), 3'(k));
            #1;
            for (int d = 0; d < 2; d++) begin
                n_checks += 2;
                if (obs_rd(d, 0) !== 16'h0000) begin
                    n_fail++; $display("FAIL clear_end_data reg%0d dut%0d: got %h expected 0000", k, d, obs_rd(d, 0));
                end
                if (obs_pd(d, 0) !== 1'b0) begin
                    n_fail++; $display("FAIL clear_end_pend reg%0d dut%0d: got %0b expected 0", k, d, obs_pd(d, 0));
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_all();
        if0.clear_req = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
        nRESET = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_busy(d) !== 1'b0) begin
                n_fail++; $display("FAIL midclear_busy dut%0d: got %0b expected 0", d, obs_busy(d));
            end
        end
        tick();
        nRESET = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_reads(3'(k), 3'(k), 3'(k));
            #1;
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs_rd(d, 0) !== 16'h0000) begin
                    n_fail++; $display("FAIL midclear_data reg%0d dut%0d: got %h expected 0000", k, d, obs_rd(d, 0));
                end
            end
        end
        set_reads(3'd1, 3'd2, 3'd3);
        if0.we_a = 1'b1; if0.waddr_a = 3'd1; if0.wdata_a = 16'h0101;
        tick();
        idle_inputs();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_rd(d, 0) !== 16'h0101) begin
                n_fail++; $display("FAIL midclear_write dut%0d: got %h expected 0101", d, obs_rd(d, 0));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if0.we_a = 1'($urandom_range(0, 1)); if0.waddr_a = 3'($urandom_range(0, 7));
            if0.wdata_a = 16'($urandom);
            if0.we_b = 1'($urandom_range(0, 1)); if0.waddr_b = 3'($urandom_range(0, 7));
            if0.wdata_b = 16'($urandom);
            if0.set_pend = 1'($urandom_range(0, 1)); if0.set_pend_addr = 3'($urandom_range(0, 7));
            if0.clear_req = ($urandom_range(0, 31) == 0);
            set_reads(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            #1;
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs_busy(d) !== exp_busy(d)) begin
                    n_fail++; $display("FAIL rand_busy dut%0d it%0d: got %0b expected %0b", d, i, obs_busy(d), exp_busy(d));
                end
                for (int n = 0; n < 3; n++) begin
                    n_checks += 2;
                    if (obs_rd(d, n) !== exp_rd(d, n)) begin
                        n_fail++; $display("FAIL rand_rdata%0d dut%0d it%0d: got %h expected %h", n, d, i, obs_rd(d, n), exp_rd(d, n));
                    end
                    if (obs_pd(d, n) !== exp_pd(d, n)) begin
                        n_fail++; $display("FAIL rand_pend%0d dut%0d it%0d: got %0b expected %0b", n, d, i, obs_pd(d, n), exp_pd(d, n));
                    end
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nRESET   = 1'b0;
        idle_inputs();
        set_reads(3'd0, 3'd0, 3'd0);
        @(negedge clk);
        test_reset();
        test_write_read();
        test_collision();
        test_scoreboard();
        test_zero_reg();
        test_soft_clear();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
